// File: rtl/multicore_cpu_pkg.sv
// Purpose: shared opcode, condition-code and instruction-field definitions for the dual-core CPU.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package multicore_cpu_pkg;

  // Opcodes in instr[31:29]; 000..011 all behave as NOP.
  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_BRA = 3'b101;
  localparam logic [2:0] OP_STR = 3'b110;
  localparam logic [2:0] OP_LD  = 3'b111;

  // Branch condition codes in instr[26:24].
  localparam logic [2:0] CC_ALWAYS = 3'b000;
  localparam logic [2:0] CC_P      = 3'b001;
  localparam logic [2:0] CC_NP     = 3'b010;
  localparam logic [2:0] CC_C      = 3'b011;
  localparam logic [2:0] CC_Z      = 3'b100;
  localparam logic [2:0] CC_N      = 3'b101;
  localparam logic [2:0] CC_NZ     = 3'b110;
  localparam logic [2:0] CC_NEVER  = 3'b111;

  // Field positions. Mode [28:27] and store flag [22] are decoded as don't-care.
  localparam int OP_LSB       = 29;
  localparam int COND_LSB     = 24;
  localparam int DST_LSB      = 11;
  localparam int SRC_LSB      = 0;
  localparam int REG_IDX_BITS = 5;
  localparam int NUM_REGS     = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  // Evaluate a branch condition against the current flags.
  function automatic logic cond_met(input logic [2:0] cond, input logic z, input logic n,
                                    input logic c, input logic p);
    logic met;
    met = 1'b0;
    case (cond)
      CC_ALWAYS: met = 1'b1;
      CC_P:      met = p;
      CC_NP:     met = !p;
      CC_C:      met = c;
      CC_Z:      met = z;
      CC_N:      met = n;
      CC_NZ:     met = !z;
      default:   met = 1'b0;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/multicore_cpu_top_cpu_core.sv
// Purpose: one single-cycle core with PC, 32-entry register file, Z/N/C/P flags and private memory.
// Latency: one instruction per clock while en=1; memory reads are combinational.
// Backpressure: en=0 freezes every register; the programming port writes only while frozen.
module cpu_core
  import multicore_cpu_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int MEM_SIZE  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 w_enable,
  input  logic [MEM_SIZE-1:0]  w_adrs,
  input  logic [DATA_SIZE-1:0] w_data,
  input  logic [MEM_SIZE-1:0]  pic_adrs,
  output logic [DATA_SIZE-1:0] pic_data,
  output logic [DATA_SIZE-1:0] result,
  output logic                 carry
);

  localparam logic [MEM_SIZE-1:0] PC_LAST = '1;

  logic [DATA_SIZE-1:0] mem  [2**MEM_SIZE];
  logic [DATA_SIZE-1:0] regs [NUM_REGS];

  logic [MEM_SIZE-1:0]     pc;
  logic                    halted;
  logic                    flag_z;
  logic                    flag_n;
  logic                    flag_p;
  logic [DATA_SIZE-1:0]    instr;
  logic [2:0]              op;
  logic [2:0]              cond;
  logic [REG_IDX_BITS-1:0] dst_reg;
  logic [REG_IDX_BITS-1:0] src_reg;
  logic [MEM_SIZE-1:0]     dst_adrs;
  logic [MEM_SIZE-1:0]     src_adrs;
  logic [DATA_SIZE-1:0]    rd_val;
  logic [DATA_SIZE-1:0]    rs_val;
  logic [DATA_SIZE-1:0]    ld_val;
  logic [DATA_SIZE-1:0]    wb_val;
  logic [DATA_SIZE:0]      sum;
  logic                    run;
  logic                    unused_instr;

  // Decode the word at PC and form the ADD/LD write-back value.
  always_comb begin
    instr        = mem[pc];
    op           = instr[OP_LSB +: 3];
    cond         = instr[COND_LSB +: 3];
    dst_reg      = instr[DST_LSB +: REG_IDX_BITS];
    src_reg      = instr[SRC_LSB +: REG_IDX_BITS];
    dst_adrs     = instr[DST_LSB +: MEM_SIZE];
    src_adrs     = instr[SRC_LSB +: MEM_SIZE];
    rd_val       = regs[dst_reg];
    rs_val       = regs[src_reg];
    ld_val       = mem[src_adrs];
    sum          = {1'b0, rd_val} + {1'b0, rs_val};
    wb_val       = (op == OP_LD) ? ld_val : sum[DATA_SIZE-1:0];
    run          = en && !halted && (pc != PC_LAST);
    unused_instr = ^instr;
  end

  assign pic_data = mem[pic_adrs];

  // Architectural state: the last word is never executed, it parks the core until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= '0;
      halted <= 1'b0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_p <= 1'b0;
      carry  <= 1'b0;
      result <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (en && !halted) begin
      if (pc == PC_LAST) begin
        halted <= 1'b1;
      end else begin
        pc <= pc + MEM_SIZE'(1);
        case (op)
          OP_ADD, OP_LD: begin
            regs[dst_reg] <= wb_val;
            flag_z        <= (wb_val == '0);
            flag_n        <= wb_val[DATA_SIZE-1];
            flag_p        <= ^wb_val;
            if (op == OP_ADD) carry <= sum[DATA_SIZE];
          end
          OP_BRA: begin
            if (cond_met(cond, flag_z, flag_n, carry, flag_p)) pc <= dst_adrs;
          end
          OP_STR: result <= rs_val;
          default: ;
        endcase
      end
    end
  end

  // Memory: programming port while frozen, STR while running; never cleared by reset.
  always_ff @(posedge clk) begin
    if (w_enable && !en) begin
      mem[w_adrs] <= w_data;
    end else if (run && !rst && (op == OP_STR)) begin
      mem[dst_adrs] <= rs_val;
    end
  end

endmodule

// File: rtl/multicore_cpu_top.sv
// Purpose: two identical cores sharing a broadcast programming port, plus a core-0 picture read port.
// Latency: picture_data is registered, one cycle after picture_radrs.
// Backpressure: none; cpu_en=0 freezes both cores and opens the programming port.
module multicore_cpu_top
  import multicore_cpu_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int MEM_SIZE  = 8
) (
  input  logic                 sys_clk,
  input  logic                 resetn,
  input  logic                 cpu_en,
  input  logic                 w_enable,
  input  logic [10:0]          w_adrs,
  input  logic [DATA_SIZE-1:0] w_instruction,
  input  logic [MEM_SIZE-1:0]  picture_radrs,
  output logic [DATA_SIZE-1:0] picture_data,
  output logic [DATA_SIZE-1:0] result,
  output logic [DATA_SIZE-1:0] result2,
  output logic                 carry,
  output logic                 carry2
);

  logic [DATA_SIZE-1:0] pic_core0;
  logic [DATA_SIZE-1:0] unused_pic_core1;
  logic                 unused_adrs_bits;

  // Upper programming-address bits are outside the memory and deliberately dropped.
  assign unused_adrs_bits = ^w_adrs[10:MEM_SIZE];

  cpu_core #(.DATA_SIZE(DATA_SIZE), .MEM_SIZE(MEM_SIZE)) u_core0 (
    .clk      (sys_clk),
    .rst      (resetn),
    .en       (cpu_en),
    .w_enable (w_enable),
    .w_adrs   (w_adrs[MEM_SIZE-1:0]),
    .w_data   (w_instruction),
    .pic_adrs (picture_radrs),
    .pic_data (pic_core0),
    .result   (result),
    .carry    (carry)
  );

  cpu_core #(.DATA_SIZE(DATA_SIZE), .MEM_SIZE(MEM_SIZE)) u_core1 (
    .clk      (sys_clk),
    .rst      (resetn),
    .en       (cpu_en),
    .w_enable (w_enable),
    .w_adrs   (w_adrs[MEM_SIZE-1:0]),
    .w_data   (w_instruction),
    .pic_adrs ('0),
    .pic_data (unused_pic_core1),
    .result   (result2),
    .carry    (carry2)
  );

  // Registered read of core-0 memory for the display block.
  always_ff @(posedge sys_clk) begin
    if (resetn) picture_data <= '0;
    else        picture_data <= pic_core0;
  end

endmodule

// File: tb/tb_multicore_cpu_top.sv
module tb_multicore_cpu_top;

  logic        sys_clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cpu_en = 1'b0;
  logic        w_enable = 1'b0;
  logic [10:0] w_adrs = '0;
  logic [31:0] w_instruction = '0;
  logic [7:0]  picture_radrs = '0;
  logic [31:0] picture_data, result, result2;
  logic        carry, carry2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] img [256];

  // Instruction-level reference model of one core (both cores must match it).
  logic [31:0] m_mem [256];
  logic [31:0] m_reg [32];
  logic        m_z, m_n, m_c, m_p, m_halt;
  int          m_pc;
  logic [31:0] m_result;

  multicore_cpu_top #(.DATA_SIZE(32), .MEM_SIZE(8)) dut (
    .sys_clk       (sys_clk),
    .resetn        (resetn),
    .cpu_en        (cpu_en),
    .w_enable      (w_enable),
    .w_adrs        (w_adrs),
    .w_instruction (w_instruction),
    .picture_radrs (picture_radrs),
    .picture_data  (picture_data),
    .result        (result),
    .result2       (result2),
    .carry         (carry),
    .carry2        (carry2)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc(input logic [2:0] op, input logic [2:0] cond,
                                      input int dst, input int src);
    enc = {op, 2'b10, cond, 3'b000, 10'(dst), 1'b0, 10'(src)};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic m_set_flags(input logic [31:0] v);
    m_z = (v == 0);
    m_n = v[31];
    m_p = ($countones(v) % 2) == 1;
  endtask

  task automatic m_step();
    logic [31:0] ins;
    longint unsigned total;
    int d, r, da, sa;
    bit take;
    if (m_halt || m_pc == 255) begin
      m_halt = 1'b1;
      return;
    end
    ins = m_mem[m_pc];
    d  = int'((ins >> 11) & 32'd31);
    da = int'((ins >> 11) & 32'd255);
    r  = int'(ins & 32'd31);
    sa = int'(ins & 32'd255);
    case (ins[31:29])
      3'd4: begin
        total = 64'(m_reg[d]) + 64'(m_reg[r]);
        m_c = total > 64'hffff_ffff;
        m_reg[d] = total[31:0];
        m_set_flags(m_reg[d]);
        m_pc = m_pc + 1;
      end
      3'd5: begin
        case (ins[26:24])
          3'd0: take = 1;
          3'd1: take = m_p;
          3'd2: take = !m_p;
          3'd3: take = m_c;
          3'd4: take = m_z;
          3'd5: take = m_n;
          3'd6: take = !m_z;
          default: take = 0;
        endcase
        m_pc = take ? da : m_pc + 1;
      end
      3'd6: begin
        m_mem[da] = m_reg[r];
        m_result = m_reg[r];
        m_pc = m_pc + 1;
      end
      3'd7: begin
        m_reg[d] = m_mem[sa];
        m_set_flags(m_reg[d]);
        m_pc = m_pc + 1;
      end
      default: m_pc = m_pc + 1;
    endcase
  endtask

  task automatic do_reset();
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    {m_z, m_n, m_c, m_p, m_halt} = '0;
    m_pc = 0;
    m_result = '0;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 32'h0;
  endtask

  // Broadcast the image through the programming port; random upper address bits must be ignored.
  task automatic load_img();
    cpu_en = 1'b0;
    for (int i = 0; i < 256; i++) begin
      w_enable = 1'b1;
      w_adrs = {3'($urandom_range(0, 7)), 8'(i)};
      w_instruction = img[i];
      tick();
      m_mem[i] = img[i];
    end
    w_enable = 1'b0;
  endtask

  task automatic run(input int n);
    cpu_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      m_step();
    end
    cpu_en = 1'b0;
  endtask

  task automatic build_mult();
    clear_img();
    img[0]   = 32'd13;
    img[1]   = 32'd11;
    img[2]   = 32'd0;
    img[255] = 32'hffff_ffff;
    img[4]   = enc(3'b111, 3'd0, 1, 0);
    img[5]   = enc(3'b111, 3'd0, 2, 1);
    img[6]   = enc(3'b111, 3'd0, 3, 255);
    img[7]   = enc(3'b111, 3'd0, 4, 2);
    img[10]  = enc(3'b100, 3'd0, 4, 1);
    img[14]  = enc(3'b100, 3'd0, 2, 3);
    img[18]  = enc(3'b101, 3'd4, 22, 0);
    img[19]  = enc(3'b101, 3'd4, 22, 0);
    img[20]  = enc(3'b101, 3'd0, 8, 0);
    img[22]  = enc(3'b110, 3'd0, 2, 4);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", result); end
    n_tests++; if (result2 !== 32'h0) begin n_fail++; $display("FAIL reset_result2 got=%h exp=0", result2); end
    n_tests++; if (carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry got=%b exp=0", carry); end
    n_tests++; if (carry2 !== 1'b0) begin n_fail++; $display("FAIL reset_carry2 got=%b exp=0", carry2); end
    n_tests++; if (picture_data !== 32'h0) begin n_fail++; $display("FAIL reset_picture got=%h exp=0", picture_data); end
  endtask

  task automatic test_multiply();
    int d_first, m_first;
    bit stable;
    build_mult();
    load_img();
    do_reset();
    picture_radrs = 8'd2;
    tick();
    n_tests++; if (picture_data !== m_mem[2]) begin n_fail++; $display("FAIL mult_pic_before got=%h exp=%h", picture_data, m_mem[2]); end
    d_first = 0; m_first = 0; stable = 1;
    cpu_en = 1'b1;
    for (int cyc = 1; cyc <= 500; cyc++) begin
      tick();
      m_step();
      if (m_first == 0 && m_result == 32'd143) m_first = cyc;
      if (d_first != 0 && result !== 32'd143) stable = 0;
      if (d_first == 0 && result === 32'd143) d_first = cyc;
    end
    cpu_en = 1'b0;
    n_tests++; if (d_first != m_first) begin n_fail++; $display("FAIL mult_cycle got=%0d exp=%0d", d_first, m_first); end
    n_tests++; if (!stable) begin n_fail++; $display("FAIL mult_stable got=unstable exp=stable"); end
    n_tests++; if (result !== 32'd143) begin n_fail++; $display("FAIL mult_result got=%h exp=%h", result, 32'd143); end
    n_tests++; if (result2 !== 32'd143) begin n_fail++; $display("FAIL mult_result2 got=%h exp=%h", result2, 32'd143); end
    n_tests++; if (carry !== m_c) begin n_fail++; $display("FAIL mult_carry got=%b exp=%b", carry, m_c); end
    n_tests++; if (carry2 !== m_c) begin n_fail++; $display("FAIL mult_carry2 got=%b exp=%b", carry2, m_c); end
    picture_radrs = 8'd2;
    tick();
    n_tests++; if (picture_data !== 32'd143) begin n_fail++; $display("FAIL mult_pic_after got=%h exp=%h", picture_data, 32'd143); end
  endtask

  task automatic test_prog_locked();
    cpu_en = 1'b1;
    w_enable = 1'b1;
    w_adrs = 11'd2;
    w_instruction = 32'h55;
    tick();
    m_step();
    w_enable = 1'b0;
    cpu_en = 1'b0;
    picture_radrs = 8'd2;
    tick();
    n_tests++; if (picture_data !== m_mem[2]) begin n_fail++; $display("FAIL locked_write got=%h exp=%h", picture_data, m_mem[2]); end
    do_reset();
    n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL midreset_result got=%h exp=0", result); end
    tick();
    n_tests++; if (picture_data !== 32'd143) begin n_fail++; $display("FAIL midreset_mem got=%h exp=%h", picture_data, 32'd143); end
  endtask

  task automatic test_add_carry();
    clear_img();
    img[200] = 32'hffff_ffff;
    img[201] = 32'h1;
    img[202] = 32'h77;
    img[0] = enc(3'b111, 3'd0, 1, 200);
    img[1] = enc(3'b111, 3'd0, 2, 201);
    img[2] = enc(3'b111, 3'd0, 10, 202);
    img[3] = enc(3'b100, 3'd0, 1, 2);
    img[4] = enc(3'b101, 3'd4, 7, 0);
    img[5] = enc(3'b110, 3'd0, 203, 2);
    img[7] = enc(3'b110, 3'd0, 204, 10);
    load_img();
    do_reset();
    run(6);
    n_tests++; if (result !== 32'h77 || result !== m_result) begin n_fail++; $display("FAIL add_branch_result got=%h exp=%h", result, 32'h77); end
    n_tests++; if (result2 !== 32'h77) begin n_fail++; $display("FAIL add_branch_result2 got=%h exp=%h", result2, 32'h77); end
    n_tests++; if (carry !== 1'b1) begin n_fail++; $display("FAIL add_carry got=%b exp=1", carry); end
    n_tests++; if (carry2 !== 1'b1) begin n_fail++; $display("FAIL add_carry2 got=%b exp=1", carry2); end
    picture_radrs = 8'd203;
    tick();
    n_tests++; if (picture_data !== 32'h0) begin n_fail++; $display("FAIL add_skipped_str got=%h exp=0", picture_data); end
    picture_radrs = 8'd204;
    tick();
    n_tests++; if (picture_data !== 32'h77) begin n_fail++; $display("FAIL add_taken_str got=%h exp=%h", picture_data, 32'h77); end
  endtask

  task automatic test_pause();
    int steps, m_first, d_first;
    build_mult();
    load_img();
    do_reset();
    steps = 0; m_first = 0; d_first = 0;
    cpu_en = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      m_step();
      steps++;
      if (m_first == 0 && m_result == 32'd143) m_first = steps;
    end
    cpu_en = 1'b0;
    repeat (20) tick();
    n_tests++; if (result !== m_result) begin n_fail++; $display("FAIL pause_frozen got=%h exp=%h", result, m_result); end
    cpu_en = 1'b1;
    for (int c = 81; c <= 600 && d_first == 0; c++) begin
      tick();
      m_step();
      steps++;
      if (m_first == 0 && m_result == 32'd143) m_first = steps;
      if (result === 32'd143) d_first = c;
    end
    cpu_en = 1'b0;
    n_tests++; if (d_first != m_first + 20) begin n_fail++; $display("FAIL pause_cycle got=%0d exp=%0d", d_first, m_first + 20); end
    n_tests++; if (result !== 32'd143) begin n_fail++; $display("FAIL pause_result got=%h exp=%h", result, 32'd143); end
  endtask

  task automatic test_nop_halt();
    clear_img();
    load_img();
    do_reset();
    run(300);
    n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL nop_result got=%h exp=0", result); end
    n_tests++; if (carry !== 1'b0) begin n_fail++; $display("FAIL nop_carry got=%b exp=0", carry); end
    img[0] = enc(3'b111, 3'd0, 1, 5);
    img[1] = enc(3'b110, 3'd0, 6, 1);
    img[5] = 32'h1234;
    load_img();
    run(20);
    n_tests++; if (result !== 32'h0 || m_result !== 32'h0) begin n_fail++; $display("FAIL halt_nowrap got=%h exp=0", result); end
    n_tests++; if (result2 !== 32'h0) begin n_fail++; $display("FAIL halt_nowrap2 got=%h exp=0", result2); end
  endtask

  task automatic test_random();
    int a;
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < 256; i++) img[i] = $urandom;
      load_img();
      do_reset();
      run(400);
      n_tests++; if (result !== m_result) begin n_fail++; $display("FAIL rnd%0d_result got=%h exp=%h", round, result, m_result); end
      n_tests++; if (result2 !== m_result) begin n_fail++; $display("FAIL rnd%0d_result2 got=%h exp=%h", round, result2, m_result); end
      n_tests++; if (carry !== m_c) begin n_fail++; $display("FAIL rnd%0d_carry got=%b exp=%b", round, carry, m_c); end
      n_tests++; if (carry2 !== m_c) begin n_fail++; $display("FAIL rnd%0d_carry2 got=%b exp=%b", round, carry2, m_c); end
      for (int k = 0; k < 4; k++) begin
        a = $urandom_range(0, 255);
        picture_radrs = 8'(a);
        tick();
        n_tests++; if (picture_data !== m_mem[a]) begin n_fail++; $display("FAIL rnd%0d_mem[%0d] got=%h exp=%h", round, a, picture_data, m_mem[a]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_prog_locked();
    test_add_carry();
    test_pause();
    test_nop_halt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
